// File: rtl/uart_rx.sv
// 8-bit UART receiver with 16x oversampling, optional odd/even parity and
// 1 or 2 stop bits. Received bytes and their error flags are presented on a
// valid/ack handshake; a frame completing while the previous byte is still
// unacknowledged is dropped and recorded in the sticky overrun flag.
module uart_rx #(
  parameter string       PARITY   = "ODD",
  parameter int unsigned STOP_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_bd_en,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       rx_par_err,
  output logic       rx_frm_err,
  output logic       rx_ovr
);

  localparam bit UsePar  = (PARITY == "ODD") || (PARITY == "EVEN");
  localparam bit ParOdd  = (PARITY == "ODD");
  localparam bit TwoStop = (STOP_BIT == 2);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StPar   = 3'd3;
  localparam logic [2:0] StStop1 = 3'd4;
  localparam logic [2:0] StStop2 = 3'd5;

  // Line synchroniser
  logic sync1_q, sync2_q;
  logic rx_s;

  // Frame FSM
  logic [2:0] state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_err_q, par_err_d;
  logic       frm_err_q, frm_err_d;
  logic       mid;
  logic       deliver;
  logic       frm_final;
  logic       par_final;

  // Upper-layer registers
  logic [7:0] data_q, data_d;
  logic       vld_q, vld_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;

  assign rx_s = sync2_q;

  // Two-flop synchroniser, runs every clock; resets to the idle line level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Mid-bit sample point; the tick counter free-runs through a frame so
  // consecutive samples are exactly 16 ticks apart.
  assign mid = rx_bd_en && (tick_q == 4'd7);

  // Frame FSM next-state: bit timing, shifting and error capture
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    deliver   = 1'b0;
    frm_final = frm_err_q;

    if (rx_bd_en) begin
      tick_d = tick_q + 4'd1;
      case (state_q)
        StIdle: begin
          tick_d = 4'd0;
          if (!rx_s) begin
            state_d = StStart;
          end
        end
        StStart: begin
          if (mid) begin
            if (rx_s) begin
              // Start bit gone high by mid-bit: treat as a glitch
              state_d = StIdle;
              tick_d  = 4'd0;
            end else begin
              state_d = StData;
              bit_d   = 3'd0;
            end
          end
        end
        StData: begin
          if (mid) begin
            shift_d[bit_q] = rx_s;
            if (bit_q == 3'd7) begin
              bit_d   = 3'd0;
              state_d = UsePar ? StPar : StStop1;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        StPar: begin
          if (mid) begin
            par_err_d = rx_s ^ (ParOdd ? ~^shift_q : ^shift_q);
            state_d   = StStop1;
          end
        end
        StStop1: begin
          if (mid) begin
            frm_err_d = ~rx_s;
            if (TwoStop) begin
              state_d = StStop2;
            end else begin
              frm_final = ~rx_s;
              deliver   = 1'b1;
              state_d   = StIdle;
            end
          end
        end
        StStop2: begin
          if (mid) begin
            frm_final = frm_err_q | ~rx_s;
            frm_err_d = frm_final;
            deliver   = 1'b1;
            state_d   = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          tick_d  = 4'd0;
        end
      endcase
    end
  end

  // Frame FSM state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tick_q    <= 4'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign par_final = UsePar ? par_err_q : 1'b0;

  // Delivery and handshake: load, drop-with-overrun, or acknowledge
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;

    if (deliver) begin
      if (!vld_q || rx_ack) begin
        data_d = shift_q;
        perr_d = par_final;
        ferr_d = frm_final;
        vld_d  = 1'b1;
        if (rx_ack) begin
          ovr_d = 1'b0;
        end
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_ack && vld_q) begin
      vld_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  // Upper-layer output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= 8'h00;
      vld_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovr_q  <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_vld     = vld_q;
  assign rx_par_err = perr_q;
  assign rx_frm_err = ferr_q;
  assign rx_ovr     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: four instances cover ODD/1, EVEN/1, NONE/1 and NONE/2.
// Each instance has its own line and ack; clock, reset and baud enable are
// shared. One bit period is 16 baud ticks = 64 clocks.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       bd_en;
  logic [3:0] rx_l;
  logic [3:0] ack_l;
  logic [7:0] dat [4];
  logic [3:0] vld, perr, ferr, ovr;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Baud enable every 4th clock
  always @(posedge clk) cyc <= cyc + 1;
  assign bd_en = (cyc[1:0] == 2'd0);

  uart_rx #(.PARITY("ODD"), .STOP_BIT(1)) u_d0 (
    .clk(clk), .rst(rst), .rx_bd_en(bd_en), .rx(rx_l[0]), .rx_ack(ack_l[0]),
    .rx_data(dat[0]), .rx_vld(vld[0]), .rx_par_err(perr[0]), .rx_frm_err(ferr[0]),
    .rx_ovr(ovr[0])
  );
  uart_rx #(.PARITY("EVEN"), .STOP_BIT(1)) u_d1 (
    .clk(clk), .rst(rst), .rx_bd_en(bd_en), .rx(rx_l[1]), .rx_ack(ack_l[1]),
    .rx_data(dat[1]), .rx_vld(vld[1]), .rx_par_err(perr[1]), .rx_frm_err(ferr[1]),
    .rx_ovr(ovr[1])
  );
  uart_rx #(.PARITY("NONE"), .STOP_BIT(1)) u_d2 (
    .clk(clk), .rst(rst), .rx_bd_en(bd_en), .rx(rx_l[2]), .rx_ack(ack_l[2]),
    .rx_data(dat[2]), .rx_vld(vld[2]), .rx_par_err(perr[2]), .rx_frm_err(ferr[2]),
    .rx_ovr(ovr[2])
  );
  uart_rx #(.PARITY("NONE"), .STOP_BIT(2)) u_d3 (
    .clk(clk), .rst(rst), .rx_bd_en(bd_en), .rx(rx_l[3]), .rx_ack(ack_l[3]),
    .rx_data(dat[3]), .rx_vld(vld[3]), .rx_par_err(perr[3]), .rx_frm_err(ferr[3]),
    .rx_ovr(ovr[3])
  );

  typedef struct {
    int         d;
    logic [7:0] data;
    logic       par;    // parity bit as driven on the line
    logic [1:0] stop;   // [0] first stop bit, [1] second
    logic [7:0] edata;
    logic       epar;
    logic       efrm;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one complete frame on instance d, starting at a fixed baud phase
  task automatic send_frame(input int d, input logic [7:0] data, input logic par,
                            input logic [1:0] stop);
    logic [11:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    nb = 9;
    if (d < 2) begin
      bits[nb] = par;
      nb++;
    end
    bits[nb] = stop[0];
    nb++;
    if (d == 3) begin
      bits[nb] = stop[1];
      nb++;
    end
    while (cyc[1:0] != 2'd1) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx_l[d] = bits[i];
      repeat (64) @(negedge clk);
    end
    rx_l[d] = 1'b1;
  endtask

  task automatic pulse_ack(input int d);
    ack_l[d] = 1'b1;
    @(negedge clk);
    ack_l[d] = 1'b0;
  endtask

  initial begin
    vt[0] = '{d: 0, data: 8'h55, par: 1'b1, stop: 2'b01, edata: 8'h55, epar: 1'b0, efrm: 1'b0};
    vt[1] = '{d: 1, data: 8'hA3, par: 1'b1, stop: 2'b01, edata: 8'hA3, epar: 1'b1, efrm: 1'b0};
    vt[2] = '{d: 2, data: 8'h0F, par: 1'b0, stop: 2'b01, edata: 8'h0F, epar: 1'b0, efrm: 1'b0};
    vt[3] = '{d: 3, data: 8'h81, par: 1'b0, stop: 2'b01, edata: 8'h81, epar: 1'b0, efrm: 1'b1};
    vt[4] = '{d: 3, data: 8'h81, par: 1'b0, stop: 2'b11, edata: 8'h81, epar: 1'b0, efrm: 1'b0};
    vt[5] = '{d: 0, data: 8'h00, par: 1'b1, stop: 2'b00, edata: 8'h00, epar: 1'b0, efrm: 1'b1};
    vt[6] = '{d: 1, data: 8'hFF, par: 1'b0, stop: 2'b01, edata: 8'hFF, epar: 1'b0, efrm: 1'b0};
    vt[7] = '{d: 0, data: 8'h01, par: 1'b1, stop: 2'b01, edata: 8'h01, epar: 1'b1, efrm: 1'b0};

    rst   = 1'b1;
    rx_l  = 4'hF;
    ack_l = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_data%0d", d), dat[d], 8'h00);
      chk($sformatf("rst_vld%0d", d), vld[d], 1'b0);
      chk($sformatf("rst_perr%0d", d), perr[d], 1'b0);
      chk($sformatf("rst_ferr%0d", d), ferr[d], 1'b0);
      chk($sformatf("rst_ovr%0d", d), ovr[d], 1'b0);
    end

    // Start-bit glitch of 4 ticks on the no-parity instance
    while (cyc[1:0] != 2'd1) @(negedge clk);
    rx_l[2] = 1'b0;
    repeat (16) @(negedge clk);
    rx_l[2] = 1'b1;
    repeat (128) @(negedge clk);
    chk("glitch_vld", vld[2], 1'b0);
    // Ack while nothing is valid is ignored
    pulse_ack(2);
    chk("idle_ack_vld", vld[2], 1'b0);
    chk("idle_ack_ovr", ovr[2], 1'b0);

    // Table of single frames, each acknowledged afterwards
    for (int i = 0; i < 8; i++) begin
      send_frame(vt[i].d, vt[i].data, vt[i].par, vt[i].stop);
      repeat (64) @(negedge clk);
      chk($sformatf("v%0d_vld", i), vld[vt[i].d], 1'b1);
      chk($sformatf("v%0d_data", i), dat[vt[i].d], vt[i].edata);
      chk($sformatf("v%0d_perr", i), perr[vt[i].d], vt[i].epar);
      chk($sformatf("v%0d_ferr", i), ferr[vt[i].d], vt[i].efrm);
      chk($sformatf("v%0d_ovr", i), ovr[vt[i].d], 1'b0);
      pulse_ack(vt[i].d);
      chk($sformatf("v%0d_ack_vld", i), vld[vt[i].d], 1'b0);
    end

    // Back-to-back frames without ack: second one dropped, overrun set
    send_frame(0, 8'h11, 1'b1, 2'b01);
    send_frame(0, 8'h22, 1'b1, 2'b01);
    repeat (64) @(negedge clk);
    chk("ovr_vld", vld[0], 1'b1);
    chk("ovr_data", dat[0], 8'h11);
    chk("ovr_flag", ovr[0], 1'b1);
    pulse_ack(0);
    chk("ovr_ack_vld", vld[0], 1'b0);
    chk("ovr_ack_flag", ovr[0], 1'b0);

    // Leave a byte pending, then reset during data bit 3 of 0x3C
    send_frame(0, 8'h77, 1'b1, 2'b01);
    repeat (64) @(negedge clk);
    chk("pre_rst_vld", vld[0], 1'b1);
    chk("pre_rst_data", dat[0], 8'h77);
    while (cyc[1:0] != 2'd1) @(negedge clk);
    rx_l[0] = 1'b0;                       // start
    repeat (64) @(negedge clk);
    rx_l[0] = 1'b0;                       // bit 0
    repeat (64) @(negedge clk);
    rx_l[0] = 1'b0;                       // bit 1
    repeat (64) @(negedge clk);
    rx_l[0] = 1'b1;                       // bit 2
    repeat (64) @(negedge clk);
    rx_l[0] = 1'b1;                       // bit 3
    repeat (32) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (16 * 64) @(negedge clk);
    chk("mid_rst_vld", vld[0], 1'b0);
    chk("mid_rst_data", dat[0], 8'h00);
    chk("mid_rst_perr", perr[0], 1'b0);
    chk("mid_rst_ferr", ferr[0], 1'b0);
    chk("mid_rst_ovr", ovr[0], 1'b0);
    send_frame(0, 8'h5A, 1'b1, 2'b01);
    repeat (64) @(negedge clk);
    chk("post_rst_vld", vld[0], 1'b1);
    chk("post_rst_data", dat[0], 8'h5A);
    chk("post_rst_perr", perr[0], 1'b0);
    chk("post_rst_ferr", ferr[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8-bit UART serial receiver; the receive-side counterpart of the team's parameterised UART transmitter.
- Frame format is identical to the transmitter's:
  - start bit (0), data LSB first, optional odd/even parity, 1 or 2 stop bits (1), line idles high.
- Oversamples the line at 16x baud, using a shared baud-tick enable.
- Hands each received byte, plus error flags, to the upper layer through a valid/ack handshake.

Parameters:
- PARITY, "ODD": "ODD" = odd parity bit expected; "EVEN" = even parity bit expected; any other value = no parity bit in the frame.
- STOP_BIT, 1: number of stop bits checked, 1 or 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_bd_en  in  1  one-clk pulse at 16x baud rate; all line sampling and bit timing advance only on clocks where this is 1
- rx  in  1  asynchronous serial line input, idle high
- rx_ack  in  1  upper layer accepts the current byte
- rx_data  out  8  received byte
- rx_vld  out  1  rx_data and flags valid; held until acknowledged
- rx_par_err  out  1  parity mismatch for the byte in rx_data
- rx_frm_err  out  1  stop bit(s) sampled low for the byte in rx_data
- rx_ovr  out  1  sticky: at least one completed frame was dropped because rx_vld was still high

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - rx_data = 0x00; rx_vld, rx_par_err, rx_frm_err, rx_ovr = 0.
  - FSM in IDLE; tick counter = 0; bit counter = 0.
  - Synchroniser flops = 1.
  - Reset asserted mid-frame abandons the frame and produces no rx_vld.
- Input path:
  - Two-flop synchroniser on rx, clocked every clk (not gated by rx_bd_en). The output rx_s is used below.
- Timing:
  - 4-bit tick counter advances on each rx_bd_en.
  - A bit is sampled when the counter = 7 (mid-bit).
  - The counter wraps 15 -> 0 at each bit boundary.
- FSM states (all transitions only on clocks where rx_bd_en = 1):
  - IDLE: if rx_s = 0, clear the tick counter and go to START.
  - START: at tick 7, if rx_s = 1 (glitch) return to IDLE; otherwise restart timing so that subsequent samples fall 16 ticks apart, and go to DATA.
  - DATA: at each mid-bit sample, shift rx_s into data[bitcnt] (LSB first). After bit 7, go to PAR if PARITY is "ODD" or "EVEN", else to STOP1.
  - PAR: at the sample, capture the parity bit. Expected value is ~^data for ODD and ^data for EVEN; par_err = (captured != expected). Go to STOP1.
  - STOP1: at the sample, frm_err = ~rx_s. If STOP_BIT = 1, deliver the byte and go to IDLE; otherwise go to STOP2.
  - STOP2: at the sample, frm_err |= ~rx_s; deliver the byte and go to IDLE.
  - Returning to IDLE at the mid-stop sample allows a back-to-back start bit to be detected.
  - Unused state encodings -> IDLE.
- Delivery (registered at the same clk edge as the final stop sample):
  - If rx_vld = 0, or rx_ack = 1 on this clock: load rx_data, rx_par_err, rx_frm_err; rx_vld = 1.
  - Otherwise: drop the new frame; rx_data and flags are unchanged; rx_ovr = 1.
  - Frames with parity or framing errors are still delivered, with their flags set.
  - With no parity, rx_par_err is always 0.
- Handshake:
  - rx_ack is sampled on every clk, independent of rx_bd_en.
  - rx_ack = 1 while rx_vld = 1 with no delivery on the same clock: rx_vld -> 0 and rx_ovr -> 0 on the next edge.
  - rx_ack = 1 while rx_vld = 0: ignored.
  - rx_ack and a delivery on the same clock: the new byte is loaded, rx_vld stays 1, and rx_ovr is cleared.
- Latency:
  - rx_vld rises on the clk edge of the final stop-bit mid-sample.
  - That is about (1 + 8 + P + S - 0.5) bit periods after the start-bit falling edge, plus 2 clk of synchroniser delay.
  - P = 1 if parity is used, else 0; S = STOP_BIT.

Test Plan:
- PARITY="ODD", STOP_BIT=1: send 0x55 with parity 1 and stop 1, 16 rx_bd_en ticks per bit -> rx_vld=1, rx_data=0x55, rx_par_err=0, rx_frm_err=0; rx_ack for one clk -> rx_vld=0 next clk.
- PARITY="EVEN": send 0xA3 with parity bit 1 (wrong; correct is 0) -> rx_data=0xA3, rx_par_err=1, rx_frm_err=0.
- Pull rx low for 4 ticks, then back high -> FSM returns to IDLE, no rx_vld. Then send 0x0F with no parity (PARITY="NONE") -> rx_data=0x0F.
- STOP_BIT=2: send 0x81 with the second stop bit driven 0 -> rx_vld=1, rx_frm_err=1. Repeat with both stop bits 1 -> rx_frm_err=0.
- Send 0x11 then 0x22 back-to-back with no rx_ack -> rx_data stays 0x11, rx_ovr=1. rx_ack -> rx_vld=0, rx_ovr=0.
- Assert rst for one clk during data bit 3 of 0x3C, then send 0x5A -> no delivery of 0x3C, all outputs 0 after reset, next frame gives rx_data=0x5A.
